// File: rtl/fpu_reservation_station_pkg.sv
// Shared typedefs for the FPU reservation station.
//   fpu_instr_t : dispatched FPU instruction with two source operands
//   operand_t   : valid=1 -> content.data holds the value, else content.tag is awaited
//   result_t    : result broadcast; only kind == RESULT_KIND_WB wakes operands
// The Message handshake is carried as flattened <name>_en / <name>_msg / <name>_reject ports.
package fpu_reservation_station_pkg;

    localparam int unsigned FPU_RS_DEPTH = 4;
    localparam int unsigned PHYS_W       = 6;
    localparam int unsigned COMMIT_W     = 6;

    localparam logic [1:0] RESULT_KIND_WB = 2'd0;

    typedef logic [PHYS_W-1:0] phys_t;

    typedef struct packed {
        logic [31:0] data;
        phys_t       tag;
    } operand_content_t;

    typedef struct packed {
        logic             valid;
        operand_content_t content;
    } operand_t;

    typedef struct packed {
        logic [COMMIT_W-1:0] commit_id;
        phys_t               dest_phys;
        logic [4:0]          dest_logic;
        logic [4:0]          funct5;
        operand_t            src1;
        operand_t            src2;
    } fpu_instr_t;

    typedef struct packed {
        phys_t       dest_phys;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        wb_t wb;
    } result_content_t;

    typedef struct packed {
        logic [1:0]      kind;
        result_content_t content;
    } result_t;

    // True when a valid writeback broadcast targets the given physical tag.
    function automatic logic wb_matches(result_t r, logic v, phys_t tag);
        return v && (r.kind == RESULT_KIND_WB) && (r.content.wb.dest_phys == tag);
    endfunction

endpackage

// File: rtl/fpu_reservation_station_rs_operand_wakeup.sv
// Combinational operand wakeup: captures broadcast data for a pending operand.
//   op_in     : operand before wakeup
//   cdb_valid : per-bus broadcast valid
//   cdb       : broadcast results
//   op_out    : operand after wakeup (lowest matching bus wins)
module rs_operand_wakeup
    import fpu_reservation_station_pkg::*;
#(
    parameter int unsigned CDB_NUM = 2
) (
    input  operand_t               op_in,
    input  logic [CDB_NUM-1:0]     cdb_valid,
    input  result_t [CDB_NUM-1:0]  cdb,
    output operand_t               op_out
);

    always_comb begin
        op_out = op_in;
        if (!op_in.valid) begin
            // Walk from the highest bus down so the lowest match is applied last.
            for (int i = int'(CDB_NUM) - 1; i >= 0; i--) begin
                if (wb_matches(cdb[i], cdb_valid[i], op_in.content.tag)) begin
                    op_out.valid        = 1'b1;
                    op_out.content.data = cdb[i].content.wb.data;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_reservation_station.sv
// FPU reservation station: collapsing age queue between dispatch and the FPU interconnect.
//   clock, reset        : clock, asynchronous active-high reset
//   flash               : synchronous flush of all entries
//   dispatch_en/msg     : incoming instruction; dispatch_reject back-pressures it
//   cdb_valid, cdb      : result broadcasts used for operand wakeup
//   issue_en/msg        : oldest ready instruction; issue_reject holds it in place
//   occupancy           : registered count of valid entries
module fpu_reservation_station
    import fpu_reservation_station_pkg::*;
#(
    parameter int unsigned DEPTH   = FPU_RS_DEPTH,
    parameter int unsigned CDB_NUM = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flash,
    input  logic                      dispatch_en,
    input  fpu_instr_t                dispatch_msg,
    output logic                      dispatch_reject,
    input  logic [CDB_NUM-1:0]        cdb_valid,
    input  result_t [CDB_NUM-1:0]     cdb,
    output logic                      issue_en,
    output fpu_instr_t                issue_msg,
    input  logic                      issue_reject,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = IdxW + 1;

    fpu_instr_t          entry_q [DEPTH];
    fpu_instr_t          entry_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [CntW-1:0]     count_q, count_d, count_rm;

    operand_t            w_src1 [DEPTH];
    operand_t            w_src2 [DEPTH];
    operand_t            d_src1, d_src2;
    fpu_instr_t          disp_woken;

    // Entries after wakeup; the extra top slot is an empty source for the shift.
    fpu_instr_t          shift_src [DEPTH+1];
    logic [DEPTH:0]      shift_valid;

    logic [DEPTH-1:0]    ready;
    logic [IdxW-1:0]     sel;
    logic                any_ready;
    logic                issue_fire, disp_fire;

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry_wakeup
        rs_operand_wakeup #(.CDB_NUM(CDB_NUM)) u_src1 (
            .op_in     (entry_q[k].src1),
            .cdb_valid (cdb_valid),
            .cdb       (cdb),
            .op_out    (w_src1[k])
        );
        rs_operand_wakeup #(.CDB_NUM(CDB_NUM)) u_src2 (
            .op_in     (entry_q[k].src2),
            .cdb_valid (cdb_valid),
            .cdb       (cdb),
            .op_out    (w_src2[k])
        );
    end

    // Dispatch-path wakeup so a broadcast in the dispatch cycle is not lost.
    rs_operand_wakeup #(.CDB_NUM(CDB_NUM)) u_disp_src1 (
        .op_in     (dispatch_msg.src1),
        .cdb_valid (cdb_valid),
        .cdb       (cdb),
        .op_out    (d_src1)
    );
    rs_operand_wakeup #(.CDB_NUM(CDB_NUM)) u_disp_src2 (
        .op_in     (dispatch_msg.src2),
        .cdb_valid (cdb_valid),
        .cdb       (cdb),
        .op_out    (d_src2)
    );

    always_comb begin
        disp_woken      = dispatch_msg;
        disp_woken.src1 = d_src1;
        disp_woken.src2 = d_src2;
        for (int k = 0; k < int'(DEPTH); k++) begin
            shift_src[k]      = entry_q[k];
            shift_src[k].src1 = w_src1[k];
            shift_src[k].src2 = w_src2[k];
            shift_valid[k]    = valid_q[k];
        end
        shift_src[DEPTH]   = '0;
        shift_valid[DEPTH] = 1'b0;
    end

    // Ready is judged on registered operands, so wakeup shows one cycle after the broadcast.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            ready[k] = valid_q[k] & entry_q[k].src1.valid & entry_q[k].src2.valid;
        end
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (ready[k]) begin
                sel       = k[IdxW-1:0];
                any_ready = 1'b1;
            end
        end
    end

    assign issue_en        = ~flash & any_ready;
    assign issue_msg       = entry_q[sel];
    assign dispatch_reject = flash | (count_q == CntW'(DEPTH));
    assign occupancy       = count_q;

    assign issue_fire = issue_en & ~issue_reject;
    assign disp_fire  = dispatch_en & ~dispatch_reject;

    always_comb begin
        count_rm = count_q - CntW'(issue_fire);
        count_d  = count_rm;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (issue_fire && (k >= int'(sel))) begin
                entry_d[k] = shift_src[k+1];
                valid_d[k] = shift_valid[k+1];
            end else begin
                entry_d[k] = shift_src[k];
                valid_d[k] = shift_valid[k];
            end
        end
        // New entry lands just above the (possibly collapsed) valid region.
        if (disp_fire) begin
            entry_d[count_rm[IdxW-1:0]] = disp_woken;
            valid_d[count_rm[IdxW-1:0]] = 1'b1;
            count_d                     = count_rm + CntW'(1);
        end
        if (flash) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q and needs no reset.
    always_ff @(posedge clock) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_fpu_reservation_station.sv
module tb_fpu_reservation_station;
    import fpu_reservation_station_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flash = 1'b0;
    logic          dispatch_en = 1'b0;
    fpu_instr_t    dispatch_msg = '0;
    logic          dispatch_reject;
    logic [1:0]    cdb_valid = '0;
    result_t [1:0] cdb = '0;
    logic          issue_en;
    fpu_instr_t    issue_msg;
    logic          issue_reject = 1'b0;
    logic [2:0]    occupancy;

    int n_vec = 0;
    int n_err = 0;

    fpu_reservation_station #(.DEPTH(4), .CDB_NUM(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .flash           (flash),
        .dispatch_en     (dispatch_en),
        .dispatch_msg    (dispatch_msg),
        .dispatch_reject (dispatch_reject),
        .cdb_valid       (cdb_valid),
        .cdb             (cdb),
        .issue_en        (issue_en),
        .issue_msg       (issue_msg),
        .issue_reject    (issue_reject),
        .occupancy       (occupancy)
    );

    always #5 clock = ~clock;

    function automatic operand_t mk_op(logic v, logic [31:0] data, phys_t tag);
        operand_t o;
        o.valid        = v;
        o.content.data = data;
        o.content.tag  = tag;
        return o;
    endfunction

    function automatic fpu_instr_t mk_instr(logic [5:0] id, operand_t s1, operand_t s2,
                                            logic [4:0] f5);
        fpu_instr_t m;
        m.commit_id  = id;
        m.dest_phys  = id;
        m.dest_logic = id[4:0];
        m.funct5     = f5;
        m.src1       = s1;
        m.src2       = s2;
        return m;
    endfunction

    function automatic result_t mk_res(logic [1:0] kind, phys_t dest, logic [31:0] data);
        result_t r;
        r.kind                 = kind;
        r.content.wb.dest_phys = dest;
        r.content.wb.data      = data;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (occupancy !== 3'd0) begin
            n_err++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        n_vec++;
        if (issue_en !== 1'b0) begin
            n_err++; $display("FAIL reset_issue_en: got %b expected 0", issue_en);
        end
        n_vec++;
        if (dispatch_reject !== 1'b0) begin
            n_err++; $display("FAIL reset_dispatch_reject: got %b expected 0", dispatch_reject);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single();
        fpu_instr_t a;
        a = mk_instr(6'd1, mk_op(1'b1, 32'h3F800000, '0), mk_op(1'b1, 32'h40000000, '0), 5'd0);
        dispatch_en = 1'b1; dispatch_msg = a;
        #1;
        n_vec++;
        if (dispatch_reject !== 1'b0 || issue_en !== 1'b0) begin
            n_err++; $display("FAIL single_pre: got rej=%b en=%b expected rej=0 en=0",
                              dispatch_reject, issue_en);
        end
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (issue_en !== 1'b1 || issue_msg !== a) begin
            n_err++; $display("FAIL single_issue: got en=%b msg=%h expected en=1 msg=%h",
                              issue_en, issue_msg, a);
        end
        n_vec++;
        if (occupancy !== 3'd1) begin
            n_err++; $display("FAIL single_occ1: got %0d expected 1", occupancy);
        end
        step();
        #1;
        n_vec++;
        if (occupancy !== 3'd0 || issue_en !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got occ=%0d en=%b expected occ=0 en=0",
                              occupancy, issue_en);
        end
    endtask

    task automatic test_wakeup();
        fpu_instr_t b, exp;
        b = mk_instr(6'd2, mk_op(1'b0, '0, 6'd5), mk_op(1'b1, 32'h3F800000, '0), 5'd3);
        dispatch_en = 1'b1; dispatch_msg = b;
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (issue_en !== 1'b0 || occupancy !== 3'd1) begin
            n_err++; $display("FAIL wake_pending: got en=%b occ=%0d expected en=0 occ=1",
                              issue_en, occupancy);
        end
        cdb[0] = mk_res(2'd1, 6'd5, 32'hDEADBEEF); cdb_valid = 2'b01;
        step();
        cdb_valid = 2'b00;
        #1;
        n_vec++;
        if (issue_en !== 1'b0) begin
            n_err++; $display("FAIL wake_non_wb_kind: got en=%b expected 0", issue_en);
        end
        cdb[1] = mk_res(2'd0, 6'd5, 32'h40400000); cdb_valid = 2'b10;
        #1;
        n_vec++;
        if (issue_en !== 1'b0) begin
            n_err++; $display("FAIL wake_same_cycle: got en=%b expected 0", issue_en);
        end
        step();
        cdb_valid = 2'b00;
        exp = b; exp.src1 = mk_op(1'b1, 32'h40400000, 6'd5);
        #1;
        n_vec++;
        if (issue_en !== 1'b1 || issue_msg !== exp) begin
            n_err++; $display("FAIL wake_issue: got en=%b msg=%h expected en=1 msg=%h",
                              issue_en, issue_msg, exp);
        end
        step();
    endtask

    task automatic test_fill_reject();
        issue_reject = 1'b1;
        for (int j = 0; j < 4; j++) begin
            dispatch_en  = 1'b1;
            dispatch_msg = mk_instr(6'(10 + j), mk_op(1'b1, 32'(j), '0),
                                    mk_op(1'b1, 32'(j + 100), '0), 5'd1);
            step();
            #1;
            n_vec++;
            if (issue_en !== 1'b1 || issue_msg.commit_id !== 6'd10) begin
                n_err++; $display("FAIL fill_head_%0d: got en=%b id=%0d expected en=1 id=10",
                                  j, issue_en, issue_msg.commit_id);
            end
        end
        dispatch_msg = mk_instr(6'd63, mk_op(1'b1, 32'h1, '0), mk_op(1'b1, 32'h2, '0), 5'd1);
        #1;
        n_vec++;
        if (occupancy !== 3'd4 || dispatch_reject !== 1'b1) begin
            n_err++; $display("FAIL fill_full: got occ=%0d rej=%b expected occ=4 rej=1",
                              occupancy, dispatch_reject);
        end
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (occupancy !== 3'd4) begin
            n_err++; $display("FAIL fill_full_hold: got occ=%0d expected 4", occupancy);
        end
        issue_reject = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_vec++;
            if (issue_en !== 1'b1 || issue_msg.commit_id !== 6'(10 + j)
                || occupancy !== 3'(4 - j)) begin
                n_err++; $display("FAIL drain_order_%0d: got en=%b id=%0d occ=%0d expected en=1 id=%0d occ=%0d",
                                  j, issue_en, issue_msg.commit_id, occupancy, 10 + j, 4 - j);
            end
            step();
        end
        #1;
        n_vec++;
        if (occupancy !== 3'd0 || issue_en !== 1'b0) begin
            n_err++; $display("FAIL drain_empty: got occ=%0d en=%b expected occ=0 en=0",
                              occupancy, issue_en);
        end
    endtask

    task automatic test_out_of_order();
        fpu_instr_t e20, e21, exp;
        e20 = mk_instr(6'd20, mk_op(1'b1, 32'h3F800000, '0), mk_op(1'b0, '0, 6'd7), 5'd1);
        e21 = mk_instr(6'd21, mk_op(1'b1, 32'h40000000, '0), mk_op(1'b1, 32'h40800000, '0), 5'd2);
        dispatch_en = 1'b1; dispatch_msg = e20;
        step();
        dispatch_msg = e21;
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (issue_en !== 1'b1 || issue_msg !== e21 || occupancy !== 3'd2) begin
            n_err++; $display("FAIL ooo_first: got en=%b msg=%h occ=%0d expected en=1 msg=%h occ=2",
                              issue_en, issue_msg, occupancy, e21);
        end
        // Both buses match tag 7 at the same edge e21 leaves; bus 0 must win.
        cdb[0] = mk_res(2'd0, 6'd7, 32'h11111111);
        cdb[1] = mk_res(2'd0, 6'd7, 32'h22222222);
        cdb_valid = 2'b11;
        step();
        cdb_valid = 2'b00;
        exp = e20; exp.src2 = mk_op(1'b1, 32'h11111111, 6'd7);
        #1;
        n_vec++;
        if (occupancy !== 3'd1) begin
            n_err++; $display("FAIL ooo_occ: got %0d expected 1", occupancy);
        end
        n_vec++;
        if (issue_en !== 1'b1 || issue_msg !== exp) begin
            n_err++; $display("FAIL ooo_shift_wake: got en=%b msg=%h expected en=1 msg=%h",
                              issue_en, issue_msg, exp);
        end
        step();
        #1;
        n_vec++;
        if (occupancy !== 3'd0) begin
            n_err++; $display("FAIL ooo_drain: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_back_to_back();
        fpu_instr_t e30, e31, e32, exp;
        e30 = mk_instr(6'd30, mk_op(1'b1, 32'h1, '0), mk_op(1'b1, 32'h2, '0), 5'd4);
        e31 = mk_instr(6'd31, mk_op(1'b1, 32'h3, '0), mk_op(1'b1, 32'h4, '0), 5'd5);
        e32 = mk_instr(6'd32, mk_op(1'b0, '0, 6'd9), mk_op(1'b1, 32'h5, '0), 5'd6);
        issue_reject = 1'b1;
        dispatch_en = 1'b1; dispatch_msg = e30;
        step();
        dispatch_msg = e31;
        step();
        issue_reject = 1'b0;
        dispatch_msg = e32;
        cdb[0] = mk_res(2'd0, 6'd9, 32'h40A00000); cdb_valid = 2'b01;
        #1;
        n_vec++;
        if (issue_msg !== e30 || occupancy !== 3'd2 || dispatch_reject !== 1'b0) begin
            n_err++; $display("FAIL b2b_pre: got msg=%h occ=%0d rej=%b expected msg=%h occ=2 rej=0",
                              issue_msg, occupancy, dispatch_reject, e30);
        end
        step();
        dispatch_en = 1'b0; cdb_valid = 2'b00;
        #1;
        n_vec++;
        if (occupancy !== 3'd2 || issue_msg !== e31) begin
            n_err++; $display("FAIL b2b_collapse: got occ=%0d msg=%h expected occ=2 msg=%h",
                              occupancy, issue_msg, e31);
        end
        step();
        exp = e32; exp.src1 = mk_op(1'b1, 32'h40A00000, 6'd9);
        #1;
        n_vec++;
        if (occupancy !== 3'd1 || issue_en !== 1'b1 || issue_msg !== exp) begin
            n_err++; $display("FAIL b2b_new_entry: got occ=%0d en=%b msg=%h expected occ=1 en=1 msg=%h",
                              occupancy, issue_en, issue_msg, exp);
        end
        step();
        #1;
        n_vec++;
        if (occupancy !== 3'd0) begin
            n_err++; $display("FAIL b2b_drain: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_flash();
        issue_reject = 1'b1;
        for (int j = 0; j < 3; j++) begin
            dispatch_en  = 1'b1;
            dispatch_msg = mk_instr(6'(40 + j), mk_op(1'b1, 32'h7, '0), mk_op(1'b1, 32'h8, '0), 5'd0);
            step();
        end
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (occupancy !== 3'd3 || issue_en !== 1'b1) begin
            n_err++; $display("FAIL flash_pre: got occ=%0d en=%b expected occ=3 en=1",
                              occupancy, issue_en);
        end
        flash = 1'b1; issue_reject = 1'b0;
        dispatch_en = 1'b1;
        dispatch_msg = mk_instr(6'd43, mk_op(1'b1, 32'h9, '0), mk_op(1'b1, 32'hA, '0), 5'd0);
        #1;
        n_vec++;
        if (issue_en !== 1'b0 || dispatch_reject !== 1'b1) begin
            n_err++; $display("FAIL flash_gate: got en=%b rej=%b expected en=0 rej=1",
                              issue_en, dispatch_reject);
        end
        step();
        flash = 1'b0; dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (occupancy !== 3'd0 || issue_en !== 1'b0 || dispatch_reject !== 1'b0) begin
            n_err++; $display("FAIL flash_clear: got occ=%0d en=%b rej=%b expected occ=0 en=0 rej=0",
                              occupancy, issue_en, dispatch_reject);
        end
    endtask

    task automatic test_async_reset();
        fpu_instr_t e60;
        issue_reject = 1'b1;
        dispatch_en = 1'b1;
        dispatch_msg = mk_instr(6'd50, mk_op(1'b1, 32'h1, '0), mk_op(1'b1, 32'h2, '0), 5'd0);
        step();
        dispatch_msg = mk_instr(6'd51, mk_op(1'b1, 32'h3, '0), mk_op(1'b1, 32'h4, '0), 5'd0);
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (occupancy !== 3'd2) begin
            n_err++; $display("FAIL arst_pre: got occ=%0d expected 2", occupancy);
        end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (occupancy !== 3'd0 || issue_en !== 1'b0 || dispatch_reject !== 1'b0) begin
            n_err++; $display("FAIL arst_clear: got occ=%0d en=%b rej=%b expected occ=0 en=0 rej=0",
                              occupancy, issue_en, dispatch_reject);
        end
        #1 reset = 1'b0;
        issue_reject = 1'b0;
        step();
        e60 = mk_instr(6'd60, mk_op(1'b1, 32'hB, '0), mk_op(1'b1, 32'hC, '0), 5'd7);
        dispatch_en = 1'b1; dispatch_msg = e60;
        step();
        dispatch_en = 1'b0;
        #1;
        n_vec++;
        if (issue_en !== 1'b1 || issue_msg !== e60 || occupancy !== 3'd1) begin
            n_err++; $display("FAIL arst_resume: got en=%b msg=%h occ=%0d expected en=1 msg=%h occ=1",
                              issue_en, issue_msg, occupancy, e60);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wakeup();
        test_fill_reject();
        test_out_of_order();
        test_back_to_back();
        test_flash();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
